forward_hazard_unit: RTL and testbench
======================================

FORWARD_HAZARD_UNIT -- requirements
Module: forward_hazard_unit

Interface
REQ-001 Parameter ADDR_W, default 5, register-address width.
REQ-002 Parameter NPORTS, default 2, number of source-operand read ports.
REQ-003 Parameter DEPTH, default 2, number of tracked downstream stages. Stage 1 = EX, stage 2 = MEM, and so on. Legal range 1..7.
REQ-004 Parameter LOAD_LAT, default 1, number of stages after EX before load data can be forwarded. Legal range 0..DEPTH-1.
REQ-005 Parameter CNT_W, default 16, stall-counter width.
REQ-006 clk  in  1  sole clock; all state updates on its rising edge.
REQ-007 reset  in  1  synchronous, active-high reset.
REQ-008 id_valid  in  1  decode holds a valid instruction.
REQ-009 id_rs  in  NPORTS*ADDR_W  source register addresses; port p occupies bits [p*ADDR_W +: ADDR_W].
REQ-010 id_rs_used  in  NPORTS  port p actually reads its source register.
REQ-011 id_rd  in  ADDR_W  destination register.
REQ-012 id_reg_write  in  1  instruction writes id_rd.
REQ-013 id_mem_read  in  1  instruction is a load.
REQ-014 flush  in  1  squash the decode instruction and stage 1.
REQ-015 stall  out  1  combinational; decode must hold its instruction this cycle.
REQ-016 ex_fwd_sel  out  NPORTS*SEL_W  registered forwarding select per port, SEL_W = clog2(DEPTH+1).
REQ-017 stall_cnt  out  CNT_W  saturating count of stall cycles.

Function
REQ-018 The unit SHALL hold a DEPTH-entry tracking pipe; each entry holds {valid, rd, wr, ld}.
REQ-019 Entry k is valid-and-writing only when valid=1, wr=1 and rd!=0.
REQ-020 Decode port p matches entry k when id_rs_used[p]=1, entry k is valid-and-writing, and rd equals port p's source address.
REQ-021 Register 0 SHALL never match.
REQ-022 For each port, the lowest-numbered (youngest) matching entry k SHALL win.
REQ-023 The select for port p SHALL be the winning k, or 0 if no entry matches.
REQ-024 stall SHALL be 1 when id_valid=1, flush=0, and any port's winning entry k has ld=1 and k<=LOAD_LAT.
REQ-025 The decode instruction issues when id_valid & ~stall & ~flush.
REQ-026 On each clock edge, entry k SHALL load entry k-1 for k = 2..DEPTH.
REQ-027 On each clock edge, entry 1 SHALL load {1, id_rd, id_reg_write, id_mem_read} on issue, and a bubble (valid=0) otherwise.
REQ-028 flush=1 SHALL force a bubble into entry 1 and SHALL invalidate the entry 1 contents entering stage 2; entries 3..DEPTH advance untouched.
REQ-029 On issue, ex_fwd_sel SHALL register the computed selects; otherwise it SHALL register 0. Latency is 1 cycle (ID decision applied in EX).
REQ-030 stall_cnt SHALL increment by 1 on each cycle where stall=1 and SHALL saturate at all-ones without wrapping.
REQ-031 Simultaneous flush and hazard: flush wins; stall=0 and nothing issues.
REQ-032 A port with id_rs_used=0 SHALL never cause stall and SHALL always get select 0.
REQ-033 After a stall bubble, the same instruction SHALL re-evaluate against the shifted pipe without external action.

Reset
REQ-034 On reset=1 at a clock edge, all entries SHALL become invalid, ex_fwd_sel SHALL become 0, and stall_cnt SHALL become 0.
REQ-035 Reset SHALL take priority over flush and issue.
REQ-036 stall SHALL read 0 in the cycle after reset (empty pipe).
REQ-037 Reset asserted mid-stall SHALL clear all hazards; the held instruction issues on the next cycle if id_valid=1.

Structure
REQ-038 A shared package SHALL hold the entry struct typedef, the SEL_W function, and the constant FWD_NONE=0.
REQ-039 One sub-module, fhu_port_match, SHALL be instantiated NPORTS times. It performs the per-port priority match and returns the winning index and its ld flag.
REQ-040 The tracking pipe and stall counter SHALL reside in the top module.

Verification
REQ-041 Producer/consumer back-to-back: issue add r3 (wr), then sub reading r3 on port 0 -> stall=0, ex_fwd_sel[0]=1 one cycle later.
REQ-042 Gap of one: add r3, nop, then reader of r3 on port 1 -> ex_fwd_sel[1]=2 with DEPTH=2; a gap of two -> 0.
REQ-043 Load-use: lw r5, then reader of r5 -> stall=1 for exactly 1 cycle, stall_cnt=1, then issue with ex_fwd_sel=2.
REQ-044 Register 0 and priority: writes to r0 never forward; two in-flight writes to r7 -> the youngest is selected (1, not 2).
REQ-045 flush during load-use stall -> stall=0, entry 1 becomes a bubble, and the next reader of r5 sees select 0.
REQ-046 Force CNT_W=4 with 20 continuous stall cycles -> stall_cnt holds 15; reset mid-stall -> stall_cnt=0 and all ex_fwd_sel=0 on the next cycle.

Source files
------------

// File: rtl/forward_hazard_unit_pkg.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_unit_pkg
// Description : Shared types and constants for the forward/hazard unit.
//               The tracking-pipe entry struct, the forwarding-select width
//               helper and the "no forward" select value.
// Revision    : 1.0 - initial release
// ============================================================================
package forward_hazard_unit_pkg;

  // Widest register address the entry struct can hold. ADDR_W must not exceed
  // it. Narrower addresses are zero-extended into the rd field.
  localparam int c_RD_MAX_W = 8;

  // Select value meaning "no in-flight producer, read the register file".
  localparam int FWD_NONE = 0;

  // One tracked downstream instruction.
  typedef struct packed {
    logic                  valid;
    logic [c_RD_MAX_W-1:0] rd;
    logic                  wr;
    logic                  ld;
  } fhu_entry_t;

  // Select width: values 0..depth need clog2(depth+1) bits.
  function automatic int fhu_sel_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fhu_port_match.sv
`default_nettype none
// ============================================================================
// Module      : fhu_port_match
// Description : Per-read-port priority match against the tracking pipe.
//               Returns the youngest matching stage (1-based) and whether
//               that producer is a load. Register 0 never matches.
// Revision    : 1.0 - initial release
// ============================================================================
module fhu_port_match
  import forward_hazard_unit_pkg::*;
#(
  parameter int ADDR_W = 5,
  parameter int DEPTH  = 2,
  parameter int SEL_W  = 2
) (
  input  logic [ADDR_W-1:0]      i_rs,
  input  logic                   i_used,
  input  fhu_entry_t [DEPTH-1:0] i_pipe,
  output logic [SEL_W-1:0]       o_sel,
  output logic                   o_ld
);

  logic [c_RD_MAX_W-1:0] w_rs_ext;

  assign w_rs_ext = c_RD_MAX_W'(i_rs);

  // Scan oldest to youngest so the youngest (lowest stage) match is left last.
  always_comb begin
    o_sel = SEL_W'(FWD_NONE);
    o_ld  = 1'b0;
    for (int k = DEPTH - 1; k >= 0; k--) begin
      if (i_used && i_pipe[k].valid && i_pipe[k].wr &&
          (i_pipe[k].rd != '0) && (i_pipe[k].rd == w_rs_ext)) begin
        o_sel = SEL_W'(k + 1);
        o_ld  = i_pipe[k].ld;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : forward_hazard_unit
// Description : Decode-stage forwarding-select and load-use stall unit.
//               Tracks DEPTH downstream stages, picks the youngest producer
//               per read port, stalls on loads whose data is not yet
//               forwardable, and counts stall cycles (saturating).
// Revision    : 1.0 - initial release
// ============================================================================
module forward_hazard_unit
  import forward_hazard_unit_pkg::*;
#(
  parameter int ADDR_W   = 5,
  parameter int NPORTS   = 2,
  parameter int DEPTH    = 2,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16,
  localparam int SEL_W   = fhu_sel_w(DEPTH)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     id_valid,
  input  logic [NPORTS*ADDR_W-1:0] id_rs,
  input  logic [NPORTS-1:0]        id_rs_used,
  input  logic [ADDR_W-1:0]        id_rd,
  input  logic                     id_reg_write,
  input  logic                     id_mem_read,
  input  logic                     flush,
  output logic                     stall,
  output logic [NPORTS*SEL_W-1:0]  ex_fwd_sel,
  output logic [CNT_W-1:0]         stall_cnt
);

  fhu_entry_t [DEPTH-1:0]  r_pipe;
  fhu_entry_t              w_new;
  logic [NPORTS*SEL_W-1:0] w_sel;
  logic [NPORTS*SEL_W-1:0] r_fwd_sel;
  logic [NPORTS-1:0]       w_ld;
  logic [NPORTS-1:0]       w_hazard;
  logic [CNT_W-1:0]        r_stall_cnt;
  logic                    w_stall;
  logic                    w_issue;

  // A port hazards when its winning producer is a load still too young.
  generate
    for (genvar p = 0; p < NPORTS; p++) begin : g_port
      fhu_port_match #(
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH),
        .SEL_W  (SEL_W)
      ) u_match (
        .i_rs   (id_rs[p*ADDR_W +: ADDR_W]),
        .i_used (id_rs_used[p]),
        .i_pipe (r_pipe),
        .o_sel  (w_sel[p*SEL_W +: SEL_W]),
        .o_ld   (w_ld[p])
      );

      assign w_hazard[p] = w_ld[p] && (w_sel[p*SEL_W +: SEL_W] <= SEL_W'(LOAD_LAT));
    end
  endgenerate

  // Flush overrides any hazard: the squashed instruction neither stalls nor issues.
  assign w_stall = id_valid && !flush && (|w_hazard);
  assign w_issue = id_valid && !w_stall && !flush;

  // Entry entering stage 1: the issuing instruction, or a bubble.
  always_comb begin
    w_new = '0;
    if (w_issue) begin
      w_new.valid = 1'b1;
      w_new.rd    = c_RD_MAX_W'(id_rd);
      w_new.wr    = id_reg_write;
      w_new.ld    = id_mem_read;
    end
  end

  // Advance the tracking pipe; flush also kills the stage-1 instruction moving on.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pipe <= '0;
    end else begin
      r_pipe[0] <= w_new;
      for (int k = 1; k < DEPTH; k++) begin
        if ((k == 1) && flush) begin
          r_pipe[k] <= '0;
        end else begin
          r_pipe[k] <= r_pipe[k-1];
        end
      end
    end
  end

  // Selects decided in decode are applied one cycle later in EX.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_fwd_sel <= '0;
    end else if (w_issue) begin
      r_fwd_sel <= w_sel;
    end else begin
      r_fwd_sel <= '0;
    end
  end

  // Saturating stall-cycle counter.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_stall_cnt <= '0;
    end else if (w_stall && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end
  end

  assign stall      = w_stall;
  assign ex_fwd_sel = r_fwd_sel;
  assign stall_cnt  = r_stall_cnt;

endmodule
`default_nettype wire

// File: tb/tb_forward_hazard_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_hazard_unit
// Description : Self-checking bench for forward_hazard_unit. Directed
//               scenarios followed by random traffic, all compared against
//               an age-indexed in-flight instruction model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_hazard_unit;
  import forward_hazard_unit_pkg::*;

  localparam int ADDR_W   = 5;
  localparam int NPORTS   = 2;
  localparam int DEPTH    = 2;
  localparam int LOAD_LAT = 1;
  localparam int CNT_W    = 4;
  localparam int SEL_W    = fhu_sel_w(DEPTH);
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  logic                     clk = 1'b0;
  logic                     reset;
  logic                     id_valid;
  logic [NPORTS*ADDR_W-1:0] id_rs;
  logic [NPORTS-1:0]        id_rs_used;
  logic [ADDR_W-1:0]        id_rd;
  logic                     id_reg_write;
  logic                     id_mem_read;
  logic                     flush;
  logic                     stall;
  logic [NPORTS*SEL_W-1:0]  ex_fwd_sel;
  logic [CNT_W-1:0]         stall_cnt;

  forward_hazard_unit #(
    .ADDR_W   (ADDR_W),
    .NPORTS   (NPORTS),
    .DEPTH    (DEPTH),
    .LOAD_LAT (LOAD_LAT),
    .CNT_W    (CNT_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .id_valid     (id_valid),
    .id_rs        (id_rs),
    .id_rs_used   (id_rs_used),
    .id_rd        (id_rd),
    .id_reg_write (id_reg_write),
    .id_mem_read  (id_mem_read),
    .flush        (flush),
    .stall        (stall),
    .ex_fwd_sel   (ex_fwd_sel),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic last_stall;

  // Model: in-flight instructions indexed by age (1 = just issued into EX).
  bit m_v  [1:DEPTH];
  int m_rd [1:DEPTH];
  bit m_wr [1:DEPTH];
  bit m_ld [1:DEPTH];
  int m_fwd;
  int m_cnt;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Youngest in-flight writer of a nonzero register rs, or 0.
  function automatic int model_sel(input int rs, input bit used);
    if (!used) return 0;
    for (int k = 1; k <= DEPTH; k++) begin
      if (m_v[k] && m_wr[k] && (m_rd[k] != 0) && (m_rd[k] == rs)) return k;
    end
    return 0;
  endfunction

  // A producer at age s is a hazard if it is a load not yet forwardable.
  function automatic bit model_haz(input int s);
    if (s == 0) return 1'b0;
    return m_ld[s] && (s <= LOAD_LAT);
  endfunction

  task automatic model_clear();
    for (int k = 1; k <= DEPTH; k++) begin
      m_v[k] = 1'b0; m_rd[k] = 0; m_wr[k] = 1'b0; m_ld[k] = 1'b0;
    end
    m_fwd = 0;
    m_cnt = 0;
  endtask

  // One clock cycle: drive, check stall mid-cycle, advance model, check registers.
  task automatic cyc(input bit v, input int rs0, input int rs1, input bit [1:0] used,
                     input int rd, input bit wr, input bit ld, input bit fl, input bit rst);
    int s0, s1;
    bit exp_stall, issue;
    id_valid     = v;
    id_rs        = {ADDR_W'(rs1), ADDR_W'(rs0)};
    id_rs_used   = used;
    id_rd        = ADDR_W'(rd);
    id_reg_write = wr;
    id_mem_read  = ld;
    flush        = fl;
    reset        = rst;
    s0 = model_sel(rs0, used[0]);
    s1 = model_sel(rs1, used[1]);
    exp_stall = v && !fl && (model_haz(s0) || model_haz(s1));
    #4;
    last_stall = stall;
    check_eq("stall", {31'd0, stall}, {31'd0, exp_stall});
    @(posedge clk);
    if (rst) begin
      model_clear();
    end else begin
      issue = v && !exp_stall && !fl;
      if (exp_stall && (m_cnt < CNT_MAX)) m_cnt++;
      m_fwd = issue ? ((s1 << SEL_W) | s0) : 0;
      for (int k = DEPTH; k >= 2; k--) begin
        m_v[k] = m_v[k-1]; m_rd[k] = m_rd[k-1]; m_wr[k] = m_wr[k-1]; m_ld[k] = m_ld[k-1];
      end
      if (fl && (DEPTH >= 2)) m_v[2] = 1'b0;
      m_v[1] = issue; m_rd[1] = rd; m_wr[1] = wr; m_ld[1] = ld;
    end
    #1;
    check_eq("ex_fwd_sel", 32'(ex_fwd_sel), 32'(m_fwd));
    check_eq("stall_cnt", 32'(stall_cnt), 32'(m_cnt));
  endtask

  initial begin
    reset = 1'b1; id_valid = 1'b0; id_rs = '0; id_rs_used = '0; id_rd = '0;
    id_reg_write = 1'b0; id_mem_read = 1'b0; flush = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset_sel", 32'(ex_fwd_sel), 32'd0);
    check_eq("reset_cnt", 32'(stall_cnt), 32'd0);

    // Back-to-back producer/consumer on port 0.
    cyc(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    cyc(1, 3, 0, 2'b01, 0, 0, 0, 0, 0);
    check_eq("b2b_stall", {31'd0, last_stall}, 32'd0);
    check_eq("b2b_sel", 32'(ex_fwd_sel), 32'h1);

    // Gap of one -> port 1 forwards from stage 2.
    cyc(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    cyc(1, 0, 3, 2'b10, 0, 0, 0, 0, 0);
    check_eq("gap1_sel", 32'(ex_fwd_sel), 32'h8);

    // Gap of two -> register file.
    cyc(1, 0, 0, 2'b00, 3, 1, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 0, 0, 0, 0, 0);
    cyc(1, 0, 3, 2'b10, 0, 0, 0, 0, 0);
    check_eq("gap2_sel", 32'(ex_fwd_sel), 32'h0);

    // Load-use: one stall, then forward from stage 2.
    cyc(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    check_eq("lu_stall", {31'd0, last_stall}, 32'd1);
    check_eq("lu_cnt", 32'(stall_cnt), 32'd1);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    check_eq("lu_stall_release", {31'd0, last_stall}, 32'd0);
    check_eq("lu_sel", 32'(ex_fwd_sel), 32'h2);

    // Register 0 never forwards; youngest of two r7 writers wins.
    cyc(1, 0, 0, 2'b00, 0, 1, 0, 0, 0);
    cyc(1, 0, 0, 2'b11, 0, 0, 0, 0, 0);
    check_eq("r0_sel", 32'(ex_fwd_sel), 32'h0);
    cyc(1, 0, 0, 2'b00, 7, 1, 0, 0, 0);
    cyc(1, 0, 0, 2'b00, 7, 1, 0, 0, 0);
    cyc(1, 7, 7, 2'b11, 0, 0, 0, 0, 0);
    check_eq("prio_sel", 32'(ex_fwd_sel), 32'h5);

    // Flush during a load-use hazard squashes the load on its way to stage 2.
    cyc(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 1, 0);
    check_eq("flush_stall", {31'd0, last_stall}, 32'd0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    check_eq("flush_sel", 32'(ex_fwd_sel), 32'h0);

    // Twenty load-use stalls saturate the 4-bit counter.
    for (int i = 0; i < 20; i++) begin
      cyc(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
      cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
      cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    end
    check_eq("sat_cnt", 32'(stall_cnt), 32'd15);

    // Reset in the middle of a stall clears everything; the reader then issues.
    cyc(1, 0, 0, 2'b00, 5, 1, 1, 0, 0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 1);
    check_eq("rst_mid_stall", {31'd0, last_stall}, 32'd1);
    check_eq("rst_cnt", 32'(stall_cnt), 32'd0);
    check_eq("rst_sel", 32'(ex_fwd_sel), 32'h0);
    cyc(1, 5, 0, 2'b01, 0, 0, 0, 0, 0);
    check_eq("post_rst_stall", {31'd0, last_stall}, 32'd0);

    // Random traffic over a small register set to provoke frequent matches.
    for (int i = 0; i < 600; i++) begin
      cyc(1'($urandom_range(0, 3) != 0),
          int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
          2'($urandom_range(0, 3)),
          int'($urandom_range(0, 7)),
          1'($urandom_range(0, 3) != 0),
          1'($urandom_range(0, 2) == 0),
          1'($urandom_range(0, 7) == 0),
          1'($urandom_range(0, 63) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
